// File: rtl/img_pkt_pkg.sv
// Shared constants, state encodings and small helpers for the image UDP packer.
package img_pkt_pkg;

    localparam logic [7:0]  HDR_MAGIC_DEF = 8'hA5;
    localparam int unsigned FIFO_DEPTH    = 2048;
    localparam int unsigned FIFO_AW       = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W         = 12;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_DONE
    } pkt_state_e;

    // Source of the word presented on the UDP data output.
    typedef enum logic [1:0] {
        SEL_ZERO,
        SEL_HDR,
        SEL_FIFO
    } out_sel_e;

    function automatic logic [15:0] byte_count(input logic [CNT_W-1:0] words);
        return (16'(words) + 16'd1) << 2;
    endfunction

    function automatic logic [31:0] make_header(input logic [7:0]  magic,
                                                input logic        sof,
                                                input logic [15:0] seq);
        return {magic, sof, 7'b0, seq};
    endfunction

endpackage

// File: rtl/sync_fifo_2048x32b.sv
// 2048x32 synchronous FIFO, show-ahead off: read data appears one cycle after
// an accepted read and holds until the next one. Writes while full are dropped.
module sync_fifo_2048x32b
    import img_pkt_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_wr_en,
    input  logic [31:0] i_wr_data,
    input  logic        i_rd_en,
    output logic [31:0] o_rd_data,
    output logic        o_full
);

    logic [31:0]        r_mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_count;
    logic               w_wr_ok;
    logic               w_rd_ok;

    assign o_full  = r_count[FIFO_AW];
    assign w_wr_ok = i_wr_en & ~o_full;
    assign w_rd_ok = i_rd_en & (r_count != '0);

    // NOTE: the storage array is deliberately not reset so it maps onto block RAM;
    // emptiness is defined by the pointers and count, which are reset.
    always_ff @(posedge i_clk) begin
        if (w_wr_ok) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            o_rd_data <= '0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
            end
            if (w_rd_ok) begin
                o_rd_data <= r_mem[r_rd_ptr];
                r_rd_ptr  <= r_rd_ptr + FIFO_AW'(1);
            end
            r_count <= r_count + {{FIFO_AW{1'b0}}, w_wr_ok} - {{FIFO_AW{1'b0}}, w_rd_ok};
        end
    end

endmodule

// File: rtl/img_udp_packer.sv
// Packs 16-bit pixels into 32-bit words, queues them in a 2048-word FIFO and
// launches header-prefixed UDP payload packets of PKT_WORDS words (plus an end-of-frame flush).
module img_udp_packer
    import img_pkt_pkg::*;
#(
    parameter int unsigned PKT_WORDS = 256,
    parameter logic [7:0]  HDR_MAGIC = HDR_MAGIC_DEF
) (
    input  logic        eth_txc_d,
    input  logic        rst,
    input  logic        img_vs,
    input  logic        img_req,
    input  logic [15:0] img_data,
    input  logic        tx_req,
    input  logic        tx_done,
    output logic        tx_start_en,
    output logic [15:0] udp_byte_num,
    output logic [31:0] udp_tx_data_img,
    output logic        pkt_wr_en,
    output logic [31:0] pkt_wr_data,
    output logic        ovf
);

    localparam logic [CNT_W-1:0] PKT_LEN = CNT_W'(PKT_WORDS);

    pkt_state_e       r_state;
    pkt_state_e       w_state_nxt;
    out_sel_e         r_out_sel;
    logic             r_vs_d, r_phase, r_wr_en, r_flush_pend, r_sof, r_ovf, r_start;
    logic [15:0]      r_pix_hi, r_pkt_seq, r_byte_num;
    logic [31:0]      r_wr_data, r_hdr;
    logic [CNT_W-1:0] r_ready_words, r_flush_words, r_len, r_idx;
    logic             w_vs_rise, w_vs_fall, w_phase, w_full, w_wr_accept;
    logic             w_launch, w_launch_flush, w_hdr_take, w_pop;
    logic [CNT_W-1:0] w_launch_len, w_flush_snap;
    logic [31:0]      w_fifo_q;

    assign w_vs_rise    = img_vs & ~r_vs_d;
    assign w_vs_fall    = ~img_vs & r_vs_d;
    // A frame start forces the pixel arriving in the same cycle to be a pair's first half.
    assign w_phase      = r_phase & ~w_vs_rise;
    assign w_wr_accept  = r_wr_en & ~w_full;
    assign w_flush_snap = CNT_W'(32'(r_ready_words) % PKT_WORDS);

    assign tx_start_en  = r_start;
    assign udp_byte_num = r_byte_num;
    assign pkt_wr_en    = r_wr_en;
    assign pkt_wr_data  = r_wr_data;
    assign ovf          = r_ovf;

    sync_fifo_2048x32b u_fifo (
        .i_clk     (eth_txc_d),
        .i_rst     (rst),
        .i_wr_en   (r_wr_en),
        .i_wr_data (r_wr_data),
        .i_rd_en   (w_pop),
        .o_rd_data (w_fifo_q),
        .o_full    (w_full)
    );

    always_ff @(posedge eth_txc_d) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt    = r_state;
        w_launch       = 1'b0;
        w_launch_flush = 1'b0;
        w_launch_len   = '0;
        w_hdr_take     = 1'b0;
        w_pop          = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_ready_words >= PKT_LEN) begin
                    w_launch     = 1'b1;
                    w_launch_len = PKT_LEN;
                    w_state_nxt  = ST_SEND;
                end else if (r_flush_pend && (r_ready_words >= r_flush_words)) begin
                    w_launch       = 1'b1;
                    w_launch_flush = 1'b1;
                    w_launch_len   = r_flush_words;
                    w_state_nxt    = ST_SEND;
                end
            end
            ST_SEND: begin
                if (tx_req) begin
                    if (r_idx == '0) begin
                        w_hdr_take = 1'b1;
                    end else begin
                        w_pop = 1'b1;
                        if (r_idx == r_len) begin
                            w_state_nxt = ST_WAIT_DONE;
                        end
                    end
                end
            end
            ST_WAIT_DONE: begin
                if (tx_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        udp_tx_data_img = '0;
        case (r_out_sel)
            SEL_HDR:  udp_tx_data_img = r_hdr;
            SEL_FIFO: udp_tx_data_img = w_fifo_q;
            default:  udp_tx_data_img = '0;
        endcase
    end

    always_ff @(posedge eth_txc_d) begin
        if (rst) begin
            r_vs_d    <= 1'b0;
            r_phase   <= 1'b0;
            r_pix_hi  <= '0;
            r_wr_en   <= 1'b0;
            r_wr_data <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_vs_d  <= img_vs;
            r_phase <= w_phase ^ img_req;
            r_wr_en <= img_req & w_phase;
            if (img_req & ~w_phase) begin
                r_pix_hi <= img_data;
            end
            if (img_req & w_phase) begin
                r_wr_data <= {r_pix_hi, img_data};
            end
            if (r_wr_en & w_full) begin
                r_ovf <= 1'b1;
            end else if (w_vs_rise) begin
                r_ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge eth_txc_d) begin
        if (rst) begin
            r_start       <= 1'b0;
            r_byte_num    <= '0;
            r_len         <= '0;
            r_idx         <= '0;
            r_hdr         <= '0;
            r_out_sel     <= SEL_ZERO;
            r_ready_words <= '0;
            r_flush_words <= '0;
            r_flush_pend  <= 1'b0;
            r_pkt_seq     <= '0;
            r_sof         <= 1'b1;
        end else begin
            r_start       <= w_launch;
            // Words committed to a packet leave the count at launch, not at pop.
            r_ready_words <= r_ready_words + CNT_W'(w_wr_accept) - w_launch_len;
            if (w_launch) begin
                r_len      <= w_launch_len;
                r_idx      <= '0;
                r_byte_num <= byte_count(w_launch_len);
            end
            if (w_hdr_take | w_pop) begin
                r_idx <= r_idx + CNT_W'(1);
            end
            if (w_hdr_take) begin
                r_hdr <= make_header(HDR_MAGIC, r_sof, r_pkt_seq);
            end
            if (tx_req) begin
                r_out_sel <= w_hdr_take ? SEL_HDR : (w_pop ? SEL_FIFO : SEL_ZERO);
            end
            if (w_vs_fall) begin
                r_flush_words <= w_flush_snap;
                r_flush_pend  <= |w_flush_snap;
            end else if (w_launch_flush) begin
                r_flush_pend <= 1'b0;
            end
            if (w_vs_rise) begin
                r_pkt_seq <= '0;
                r_sof     <= 1'b1;
            end else if ((r_state == ST_WAIT_DONE) && tx_done) begin
                r_pkt_seq <= r_pkt_seq + 16'd1;
                r_sof     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_img_udp_packer.sv
// Directed-sequence bench with random pixel data; expected packets come from a
// frame-level model (pair pixels, cap at FIFO depth, split into PKT-word chunks).
module tb_img_udp_packer;

    localparam int PKT = 256;
    localparam int BIG = 1 << 30;

    logic        clk;
    logic        rst;
    logic        img_vs;
    logic        img_req;
    logic [15:0] img_data;
    logic        tx_req;
    logic        tx_done;
    logic        tx_start_en;
    logic [15:0] udp_byte_num;
    logic [31:0] udp_tx_data_img;
    logic        pkt_wr_en;
    logic [31:0] pkt_wr_data;
    logic        ovf;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_q[$];
    logic [15:0] start_bytes[$];

    img_udp_packer #(.PKT_WORDS(PKT)) dut (
        .eth_txc_d       (clk),
        .rst             (rst),
        .img_vs          (img_vs),
        .img_req         (img_req),
        .img_data        (img_data),
        .tx_req          (tx_req),
        .tx_done         (tx_done),
        .tx_start_en     (tx_start_en),
        .udp_byte_num    (udp_byte_num),
        .udp_tx_data_img (udp_tx_data_img),
        .pkt_wr_en       (pkt_wr_en),
        .pkt_wr_data     (pkt_wr_data),
        .ovf             (ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Record every launch with the byte count presented alongside it.
    always @(negedge clk) begin
        if (tx_start_en) start_bytes.push_back(udp_byte_num);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] header(input int seq);
        return {8'hA5, (seq == 0), 7'b0, 16'(seq)};
    endfunction

    // Drive one frame; the model keeps at most 'cap' words (FIFO capacity when nothing drains).
    task automatic run_frame(input int n_pix, input bit gaps, input int cap);
        logic [15:0] hi;
        logic [31:0] word;
        bit          sec;
        int          i;
        int          kept;
        hi = '0; word = '0; i = 0; kept = 0;
        img_vs = 1'b1;
        @(negedge clk);
        while (i < n_pix) begin
            sec     = 1'b0;
            img_req = 1'b0;
            if (!gaps || $urandom_range(0, 3) != 0) begin
                img_req  = 1'b1;
                img_data = 16'($urandom);
                if (i % 2 == 0) begin
                    hi = img_data;
                end else begin
                    sec  = 1'b1;
                    word = {hi, img_data};
                    if (kept < cap) begin
                        exp_q.push_back(word);
                        kept++;
                    end
                end
                i++;
            end
            @(negedge clk);
            check("pkt_wr_en", 32'(pkt_wr_en), 32'(sec));
            if (sec) check("pkt_wr_data", pkt_wr_data, word);
        end
        img_req = 1'b0;
        repeat (4) @(negedge clk);
        img_vs = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_start(output bit ok);
        int n;
        n = 0;
        while (start_bytes.size() == 0 && n < 6000) begin
            @(negedge clk);
            n++;
        end
        ok = (start_bytes.size() != 0);
    endtask

    task automatic serve_packet(input int len, input logic [31:0] hdr, input bit gaps, input bit extra);
        bit          ok;
        logic [31:0] exp_w;
        logic [15:0] bytes;
        wait_start(ok);
        check("start_seen", 32'(ok), 32'd1);
        if (!ok) begin
            exp_q.delete();
            return;
        end
        bytes = start_bytes.pop_front();
        check("udp_byte_num", 32'(bytes), 32'(4 * (len + 1)));
        for (int k = 0; k <= len; k++) begin
            exp_w   = (k == 0) ? hdr : exp_q.pop_front();
            tx_req  = 1'b1;
            tx_done = gaps && (k == 1);
            @(negedge clk);
            tx_req  = 1'b0;
            tx_done = 1'b0;
            check("tx_data", udp_tx_data_img, exp_w);
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    @(negedge clk);
                    check("tx_hold", udp_tx_data_img, exp_w);
                end
            end
        end
        if (extra) begin
            tx_req = 1'b1;
            @(negedge clk);
            tx_req = 1'b0;
            check("tx_beyond_len", udp_tx_data_img, 32'd0);
        end
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    task automatic serve_frame(input bit gaps, input bit extra_first);
        int seq;
        int len;
        seq = 0;
        while (exp_q.size() > 0) begin
            len = (exp_q.size() >= PKT) ? PKT : exp_q.size();
            serve_packet(len, header(seq), gaps, extra_first && (seq == 0));
            seq++;
        end
        repeat (50) @(negedge clk);
        check("no_extra_start", 32'(start_bytes.size()), 32'd0);
    endtask

    initial begin
        bit          ok;
        logic [15:0] bytes;
        logic [31:0] exp_w;
        rst = 1'b1; img_vs = 1'b0; img_req = 1'b0; img_data = '0; tx_req = 1'b0; tx_done = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_start", 32'(tx_start_en), 32'd0);
        check("rst_bytes", 32'(udp_byte_num), 32'd0);
        check("rst_data", udp_tx_data_img, 32'd0);
        check("rst_wr_en", 32'(pkt_wr_en), 32'd0);
        check("rst_wr_data", pkt_wr_data, 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;

        // Requests and done pulses while idle are ignored.
        tx_req = 1'b1; tx_done = 1'b1;
        @(negedge clk);
        tx_req = 1'b0; tx_done = 1'b0;
        check("idle_req_data", udp_tx_data_img, 32'd0);
        repeat (5) @(negedge clk);
        check("idle_no_start", 32'(start_bytes.size()), 32'd0);

        // 1024 pixels: two full packets, continuous requests plus one beyond the end.
        run_frame(1024, 1'b0, BIG);
        serve_frame(1'b0, 1'b1);

        // 600 pixels: one full packet then a 44-word flush, requests with gaps.
        run_frame(600, 1'b1, BIG);
        serve_frame(1'b1, 1'b0);

        // 513 pixels: trailing pixel discarded, the next frame must start a fresh pair.
        run_frame(513, 1'b0, BIG);
        serve_frame(1'b0, 1'b0);

        // Overfill with nothing draining: surplus dropped, ovf sticky until next frame.
        check("ovf_before", 32'(ovf), 32'd0);
        run_frame(4200, 1'b0, 2048);
        check("ovf_set", 32'(ovf), 32'd1);
        serve_frame(1'b0, 1'b0);
        check("ovf_sticky", 32'(ovf), 32'd1);

        // Reset in the middle of a packet.
        run_frame(512, 1'b0, BIG);
        check("ovf_cleared", 32'(ovf), 32'd0);
        wait_start(ok);
        check("rst_pkt_start", 32'(ok), 32'd1);
        if (start_bytes.size() != 0) bytes = start_bytes.pop_front();
        for (int k = 0; k <= 10; k++) begin
            exp_w  = (k == 0) ? 32'hA580_0000 : exp_q.pop_front();
            tx_req = 1'b1;
            @(negedge clk);
            tx_req = 1'b0;
            check("pre_rst_data", udp_tx_data_img, exp_w);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        check("mid_rst_start", 32'(tx_start_en), 32'd0);
        check("mid_rst_bytes", 32'(udp_byte_num), 32'd0);
        check("mid_rst_data", udp_tx_data_img, 32'd0);
        check("mid_rst_wr_en", 32'(pkt_wr_en), 32'd0);
        check("mid_rst_ovf", 32'(ovf), 32'd0);
        repeat (300) @(negedge clk);
        check("post_rst_no_start", 32'(start_bytes.size()), 32'd0);
        run_frame(512, 1'b0, BIG);
        serve_frame(1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
